// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and widths for the IF/MEM memory port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_D
  } arb_state_t;

  typedef enum logic {
    REQ_IF,
    REQ_D
  } requester_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side signals of the arbiter.
// master is the arbiter's view; slave is the view of the requesters and memory.
interface mem_port_arbiter_if;
  import mem_arb_pkg::*;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              if_err;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_be;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  if_req, if_addr, if_flush,
    output if_gnt, if_rvalid, if_rdata, if_err,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    output if_req, if_addr, if_flush,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_timeout_ctr.sv
// Counts BUSY cycles without an ack and flags expiry on the last allowed cycle.
// TIMEOUT of 0 removes the counter entirely.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expire = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(TIMEOUT + 1);
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

      logic [CW-1:0] count_q, count_d;

      always_comb begin
        count_d = count_q;
        if (clear) begin
          count_d = '0;
        end else if (enable && count_q != LAST) begin
          count_d = count_q + CW'(1);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          count_q <= '0;
        end else begin
          count_q <= count_d;
        end
      end

      assign expire = enable && (count_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store, one access in flight,
// data first with a streak limit so fetch cannot starve.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.master bus
);

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  arb_state_t        state_q, state_d;
  logic [SW-1:0]     streak_q, streak_d, streak_inc;
  logic              discard_q, discard_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic              if_rvalid_q, if_rvalid_d, if_err_q, if_err_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              d_rvalid_q, d_rvalid_d, d_err_q, d_err_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic       fetch_pend, grant_data, grant_fetch, busy;
  logic       ack_done, to_done, expire, to_clear, to_enable;
  requester_t grant_who;

  assign fetch_pend  = bus.if_req && !bus.if_flush;
  assign grant_data  = (state_q == IDLE) && bus.d_req &&
                       !(fetch_pend && streak_q == STREAK_MAX);
  assign grant_fetch = (state_q == IDLE) && !grant_data && fetch_pend;
  assign grant_who   = grant_data ? REQ_D : REQ_IF;
  assign busy        = (state_q != IDLE);
  assign ack_done    = busy && bus.mem_ack;
  assign to_done     = busy && !bus.mem_ack && expire;
  assign to_clear    = grant_data || grant_fetch;
  assign to_enable   = busy && !bus.mem_ack;
  assign streak_inc  = (streak_q == STREAK_MAX) ? streak_q : streak_q + SW'(1);

  mem_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clear (to_clear),
    .enable(to_enable),
    .expire(expire)
  );

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    discard_d   = discard_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_rvalid_d = 1'b0;
    if_err_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rvalid_d  = 1'b0;
    d_err_d     = 1'b0;
    d_rdata_d   = d_rdata_q;

    if (grant_data || grant_fetch) begin
      mem_req_d = 1'b1;
      if (grant_who == REQ_D) begin
        state_d     = BUSY_D;
        mem_we_d    = bus.d_we;
        mem_addr_d  = bus.d_addr;
        mem_wdata_d = bus.d_wdata;
        mem_be_d    = bus.d_be;
        streak_d    = fetch_pend ? streak_inc : '0;
      end else begin
        state_d     = BUSY_IF;
        mem_we_d    = 1'b0;
        mem_addr_d  = bus.if_addr;
        mem_wdata_d = '0;
        mem_be_d    = {BE_W{1'b1}};
        streak_d    = '0;
      end
    end

    // A redirect while fetching lets the bus access finish but drops its result.
    if (state_q == BUSY_IF && bus.if_flush) begin
      discard_d = 1'b1;
    end

    if (ack_done || to_done) begin
      state_d   = IDLE;
      mem_req_d = 1'b0;
      discard_d = 1'b0;
      if (state_q == BUSY_IF) begin
        if (!(discard_q || bus.if_flush)) begin
          if_rvalid_d = 1'b1;
          if_err_d    = to_done;
          if_rdata_d  = ack_done ? bus.mem_rdata : '0;
        end
      end else begin
        d_rvalid_d = 1'b1;
        d_err_d    = to_done;
        d_rdata_d  = ack_done ? bus.mem_rdata : '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      discard_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rvalid_q  <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      discard_q   <= discard_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_rvalid_q <= if_rvalid_d;
      if_err_q    <= if_err_d;
      if_rdata_q  <= if_rdata_d;
      d_rvalid_q  <= d_rvalid_d;
      d_err_q     <= d_err_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Grants are combinational, so they are masked to honour an in-progress reset.
  assign bus.if_gnt    = grant_fetch && !rst;
  assign bus.d_gnt     = grant_data && !rst;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_err    = if_err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_err     = d_err_q;
  assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected completions into
// a scoreboard queue that a separate monitor pops whenever an rvalid appears.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  typedef struct packed {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk;
  logic rst;
  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .MAX_STREAK(4),
    .TIMEOUT   (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          vectors = 0;
  int          miscompares = 0;
  int          ack_delay = 1;
  int          wait_cnt = 0;
  logic [31:0] resp_data = 32'h0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compares one observed value against its hand-computed expectation.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Raises one request with its fields, just after a rising edge.
  task automatic applyStimulus(input logic is_d, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be);
    @(posedge clk);
    #1;
    if (is_d) begin
      bus.d_req   = 1'b1;
      bus.d_we    = we;
      bus.d_addr  = addr;
      bus.d_wdata = wdata;
      bus.d_be    = be;
    end else begin
      bus.if_req  = 1'b1;
      bus.if_addr = addr;
    end
  endtask

  task automatic pushExp(input logic is_d, input logic [31:0] rdata, input logic err);
    exp_t e;
    e.is_d  = is_d;
    e.rdata = rdata;
    e.err   = err;
    sb_q.push_back(e);
  endtask

  task automatic dropReqs();
    @(posedge clk);
    #1;
    bus.if_req  = 1'b0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h0;
    bus.d_wdata = 32'h0;
    bus.d_be    = 4'h0;
  endtask

  // Memory model: acks ack_delay cycles after mem_req is first seen.
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_ack = 1'b0;
      if (bus.mem_req) begin
        if (wait_cnt == ack_delay) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = resp_data;
          wait_cnt      = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: checks each completion against the scoreboard and grant legality.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.if_gnt || bus.d_gnt) begin
          checkOutput("gnt_while_busy", 32'(bus.mem_req), 32'h0);
          checkOutput("dual_gnt", 32'(bus.if_gnt && bus.d_gnt), 32'h0);
        end
        if (bus.if_rvalid || bus.d_rvalid) begin
          if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_rvalid: got if_rvalid=%0b d_rvalid=%0b, required none",
                     bus.if_rvalid, bus.d_rvalid);
          end else begin
            mon_e = sb_q.pop_front();
            checkOutput("rvalid_d", 32'(bus.d_rvalid), 32'(mon_e.is_d));
            checkOutput("rvalid_if", 32'(bus.if_rvalid), 32'(!mon_e.is_d));
            checkOutput("rdata", mon_e.is_d ? bus.d_rdata : bus.if_rdata, mon_e.rdata);
            checkOutput("err", 32'(mon_e.is_d ? bus.d_err : bus.if_err), 32'(mon_e.err));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [9:0] order;
    int         n;
    int         hi;
    bit         done;

    rst          = 1'b1;
    bus.if_req   = 1'b0;
    bus.if_addr  = 32'h0;
    bus.if_flush = 1'b0;
    bus.d_req    = 1'b0;
    bus.d_we     = 1'b0;
    bus.d_addr   = 32'h0;
    bus.d_wdata  = 32'h0;
    bus.d_be     = 4'h0;

    #12;
    checkOutput("rst_mem_req", 32'(bus.mem_req), 32'h0);
    checkOutput("rst_if_gnt", 32'(bus.if_gnt), 32'h0);
    checkOutput("rst_d_gnt", 32'(bus.d_gnt), 32'h0);
    checkOutput("rst_rvalid", 32'({bus.if_rvalid, bus.d_rvalid}), 32'h0);
    checkOutput("rst_mem_addr", bus.mem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] test 1: single fetch");
    resp_data = 32'hDEADBEEF;
    ack_delay = 2;
    pushExp(1'b0, 32'hDEADBEEF, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h100, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("t1_if_gnt", 32'(bus.if_gnt), 32'h1);
    checkOutput("t1_mem_req_n", 32'(bus.mem_req), 32'h0);
    dropReqs();
    @(negedge clk);
    checkOutput("t1_mem_req_n1", 32'(bus.mem_req), 32'h1);
    checkOutput("t1_mem_addr", bus.mem_addr, 32'h100);
    checkOutput("t1_mem_we", 32'(bus.mem_we), 32'h0);
    checkOutput("t1_mem_be", 32'(bus.mem_be), 32'hF);
    @(negedge clk);
    checkOutput("t1_mem_req_n2", 32'(bus.mem_req), 32'h1);
    @(negedge clk);
    checkOutput("t1_mem_req_n3", 32'(bus.mem_req), 32'h1);
    @(negedge clk);
    checkOutput("t1_mem_req_n4", 32'(bus.mem_req), 32'h0);
    checkOutput("t1_if_rvalid_n4", 32'(bus.if_rvalid), 32'h1);

    $display("[TB] test 2: streak limit");
    resp_data = 32'h11112222;
    ack_delay = 1;
    for (int i = 0; i < 10; i++) begin
      pushExp((i % 5) != 4, 32'h11112222, 1'b0);
    end
    @(posedge clk);
    #1;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h104;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h300;
    bus.d_be    = 4'hF;
    order = '0;
    n = 0;
    for (int c = 0; c < 80 && n < 10; c++) begin
      @(negedge clk);
      if (bus.if_gnt || bus.d_gnt) begin
        order = {order[8:0], bus.d_gnt};
        n++;
      end
    end
    dropReqs();
    checkOutput("t2_grant_count", 32'(n), 32'd10);
    checkOutput("t2_grant_order", 32'(order), 32'(10'b1111011110));
    repeat (4) @(negedge clk);

    $display("[TB] test 3: store");
    resp_data = 32'h000000AA;
    ack_delay = 3;
    pushExp(1'b1, 32'h000000AA, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h2000, 32'h12345678, 4'b0011);
    @(negedge clk);
    checkOutput("t3_d_gnt", 32'(bus.d_gnt), 32'h1);
    dropReqs();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checkOutput("t3_mem_req", 32'(bus.mem_req), 32'h1);
      checkOutput("t3_mem_we", 32'(bus.mem_we), 32'h1);
      checkOutput("t3_mem_be", 32'(bus.mem_be), 32'h3);
      checkOutput("t3_mem_wdata", bus.mem_wdata, 32'h12345678);
      checkOutput("t3_mem_addr", bus.mem_addr, 32'h2000);
    end
    checkOutput("t3_ack_n4", 32'(bus.mem_ack), 32'h1);
    @(negedge clk);
    checkOutput("t3_d_rvalid", 32'(bus.d_rvalid), 32'h1);
    checkOutput("t3_mem_req_off", 32'(bus.mem_req), 32'h0);

    $display("[TB] test 4: fetch flush");
    resp_data = 32'h5555AAAA;
    ack_delay = 3;
    applyStimulus(1'b0, 1'b0, 32'h200, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("t4_if_gnt", 32'(bus.if_gnt), 32'h1);
    @(posedge clk);
    #1;
    bus.if_req   = 1'b0;
    bus.if_flush = 1'b1;
    @(posedge clk);
    #1;
    bus.if_flush = 1'b0;
    @(negedge clk);
    checkOutput("t4_mem_req_busy", 32'(bus.mem_req), 32'h1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t4_ack", 32'(bus.mem_ack), 32'h1);
    resp_data = 32'h600D600D;
    ack_delay = 1;
    pushExp(1'b0, 32'h600D600D, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h204, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("t4_no_if_rvalid", 32'(bus.if_rvalid), 32'h0);
    checkOutput("t4_mem_req_off", 32'(bus.mem_req), 32'h0);
    checkOutput("t4_regrant", 32'(bus.if_gnt), 32'h1);
    dropReqs();
    repeat (4) @(negedge clk);

    $display("[TB] test 5: ack timeout");
    for (int r = 0; r < 2; r++) begin
      if (r == 0) begin
        ack_delay = 1000;
        pushExp(1'b1, 32'h0, 1'b1);
      end else begin
        resp_data = 32'hCAFEF00D;
        ack_delay = 7;
        pushExp(1'b1, 32'hCAFEF00D, 1'b0);
      end
      applyStimulus(1'b1, 1'b0, 32'h400, 32'h0, 4'hF);
      @(negedge clk);
      checkOutput("t5_d_gnt", 32'(bus.d_gnt), 32'h1);
      dropReqs();
      hi = 0;
      done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
        @(negedge clk);
        if (bus.mem_req) hi++;
        else done = 1'b1;
      end
      checkOutput("t5_req_cycles", 32'(hi), 32'd8);
      checkOutput("t5_d_rvalid", 32'(bus.d_rvalid), 32'h1);
      checkOutput("t5_d_err", 32'(bus.d_err), (r == 0) ? 32'h1 : 32'h0);
      checkOutput("t5_d_rdata", bus.d_rdata, (r == 0) ? 32'h0 : 32'hCAFEF00D);
      repeat (2) @(negedge clk);
    end

    $display("[TB] test 6: asynchronous reset mid-access");
    resp_data = 32'h77770001;
    ack_delay = 1;
    pushExp(1'b1, 32'h77770001, 1'b0);
    pushExp(1'b1, 32'h77770001, 1'b0);
    @(posedge clk);
    #1;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h500;
    bus.d_req   = 1'b1;
    bus.d_addr  = 32'h600;
    n = 0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      @(negedge clk);
      if (bus.d_gnt) n++;
    end
    ack_delay = 1000;
    checkOutput("t6_d_grants", 32'(n), 32'd3);
    repeat (2) @(negedge clk);
    checkOutput("t6_busy_before_rst", 32'(bus.mem_req), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_mem_req", 32'(bus.mem_req), 32'h0);
    checkOutput("t6_rst_gnt", 32'({bus.if_gnt, bus.d_gnt}), 32'h0);
    checkOutput("t6_rst_rvalid", 32'({bus.if_rvalid, bus.d_rvalid}), 32'h0);
    bus.d_req = 1'b0;
    resp_data = 32'h33334444;
    ack_delay = 1;
    @(posedge clk);
    #3;
    rst = 1'b0;
    pushExp(1'b0, 32'h33334444, 1'b0);
    @(negedge clk);
    checkOutput("t6_if_gnt_first", 32'(bus.if_gnt), 32'h1);
    checkOutput("t6_no_d_gnt", 32'(bus.d_gnt), 32'h0);
    dropReqs();
    repeat (6) @(negedge clk);

    checkOutput("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
